// File: rtl/id_regfile_sb_pkg.sv
// id_pkg: shared defaults, register index type and load latency bounds for the ID-stage register file
package id_pkg;
   localparam int XLEN_DEF     = 32;
   localparam int NREG_DEF     = 32;
   localparam int NRD_DEF      = 2;
   localparam int LOAD_LAT_MIN = 1;
   localparam int LOAD_LAT_MAX = 7;
   typedef logic [$clog2(NREG_DEF)-1:0] reg_idx_t;
endpackage

// File: rtl/id_regfile_sb_if.sv
// id_regfile_sb_if: decode-side, writeback and ID/EX signals of the register file block
interface id_regfile_sb_if import id_pkg::*; #(
   parameter int XLEN = XLEN_DEF,
   parameter int NREG = NREG_DEF,
   parameter int NRD  = NRD_DEF
);
   localparam int RW = $clog2(NREG);
   logic                 in_valid;
   logic [NRD*RW-1:0]    in_rs;
   logic [NRD-1:0]       in_src_used;
   logic [RW-1:0]        in_dst;
   logic                 in_dst_we;
   logic                 in_is_load;
   logic                 flush;
   logic                 wr_en;
   logic [RW-1:0]        wr_addr;
   logic [XLEN-1:0]      wr_data;
   logic                 out_valid;
   logic [NRD*XLEN-1:0]  out_data;
   logic [NRD*RW-1:0]    out_rs;
   logic [RW-1:0]        out_dst;
   logic                 out_dst_we;
   logic                 out_is_load;
   logic                 hold;
   modport master (
      output in_valid, in_rs, in_src_used, in_dst, in_dst_we, in_is_load, flush, wr_en, wr_addr, wr_data,
      input  out_valid, out_data, out_rs, out_dst, out_dst_we, out_is_load, hold
   );
   modport slave (
      input  in_valid, in_rs, in_src_used, in_dst, in_dst_we, in_is_load, flush, wr_en, wr_addr, wr_data,
      output out_valid, out_data, out_rs, out_dst, out_dst_we, out_is_load, hold
   );
endinterface

// File: rtl/id_regfile_sb_scoreboard.sv
// id_scoreboard: per-register load countdown, operand hazard detection (hold) and issue decision
// ID_RF_BYPASS_EN undefined: a same-cycle writeback to a source register also stalls
module id_scoreboard import id_pkg::*; #(
   parameter int NREG     = NREG_DEF,
   parameter int NRD      = NRD_DEF,
   parameter int LOAD_LAT = 1,
   localparam int RW      = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [NRD*RW-1:0] in_rs,
   input  logic [NRD-1:0]    in_src_used,
   input  logic [RW-1:0]     in_dst,
   input  logic              in_dst_we,
   input  logic              in_is_load,
   input  logic              flush,
`ifndef ID_RF_BYPASS_EN
   input  logic              wr_en,
   input  logic [RW-1:0]     wr_addr,
`endif
   output logic              hold,
   output logic              issue
);
   localparam int CW = $clog2(LOAD_LAT+1);
   logic [CW-1:0] cnt [NREG];
   logic          haz;
   logic          set;
   // any used nonzero source whose producer is still in flight
   always_comb begin
      haz = 1'b0;
      for (int i = 0; i < NRD; i++)
         haz = haz | (in_src_used[i] && in_rs[i*RW +: RW] != '0 && (cnt[in_rs[i*RW +: RW]] != '0
`ifndef ID_RF_BYPASS_EN
               || (wr_en && wr_addr == in_rs[i*RW +: RW])
`endif
               ));
   end
   assign hold  = ~rst & in_valid & haz;
   assign issue = in_valid & ~hold & ~flush;
   assign set   = issue & in_is_load & in_dst_we & (in_dst != '0);
   // a fresh load reloads its counter, every other busy counter drains by one
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '{default: '0};
      else
         for (int r = 1; r < NREG; r++)
            cnt[r] <= (set && in_dst == RW'(r)) ? CW'(LOAD_LAT) : cnt[r] - CW'(cnt[r] != '0);
endmodule

// File: rtl/id_regfile_sb.sv
// id_regfile_sb: register file with load-use scoreboard and ID/EX pipeline register
// ID_RF_BYPASS_EN defined: reads of the register being written return wr_data
module id_regfile_sb import id_pkg::*; #(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREG     = NREG_DEF,
   parameter int NRD      = NRD_DEF,
   parameter int LOAD_LAT = 1
) (
   input logic clk,
   input logic rst,
   id_regfile_sb_if.slave bus
);
   localparam int RW = $clog2(NREG);
   logic [XLEN-1:0]     regs [NREG];
   logic [NRD*XLEN-1:0] rd_data;
   logic                issue;
   id_scoreboard #(.NREG(NREG), .NRD(NRD), .LOAD_LAT(LOAD_LAT)) u_sb (
      .clk(clk),
      .rst(rst),
      .in_valid(bus.in_valid),
      .in_rs(bus.in_rs),
      .in_src_used(bus.in_src_used),
      .in_dst(bus.in_dst),
      .in_dst_we(bus.in_dst_we),
      .in_is_load(bus.in_is_load),
      .flush(bus.flush),
`ifndef ID_RF_BYPASS_EN
      .wr_en(bus.wr_en),
      .wr_addr(bus.wr_addr),
`endif
      .hold(bus.hold),
      .issue(issue)
   );
   // writeback; register 0 is hardwired to zero
   always_ff @(posedge clk or posedge rst)
      if (rst) regs <= '{default: '0};
      else if (bus.wr_en && bus.wr_addr != '0) regs[bus.wr_addr] <= bus.wr_data;
   // combinational operand read per source port
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NRD; i++)
         rd_data[i*XLEN +: XLEN] = (bus.in_rs[i*RW +: RW] == '0) ? '0 :
`ifdef ID_RF_BYPASS_EN
            (bus.wr_en && bus.wr_addr == bus.in_rs[i*RW +: RW]) ? bus.wr_data :
`endif
            regs[bus.in_rs[i*RW +: RW]];
   end
   // ID/EX register: capture on issue, bubble otherwise
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bus.out_valid   <= 1'b0;
         bus.out_data    <= '0;
         bus.out_rs      <= '0;
         bus.out_dst     <= '0;
         bus.out_dst_we  <= 1'b0;
         bus.out_is_load <= 1'b0;
      end else begin
         bus.out_valid <= issue;
         if (issue) begin
            bus.out_data    <= rd_data;
            bus.out_rs      <= bus.in_rs;
            bus.out_dst     <= bus.in_dst;
            bus.out_dst_we  <= bus.in_dst_we;
            bus.out_is_load <= bus.in_is_load;
         end
      end
endmodule
